// File: rtl/fetch.sv
// Instruction fetch stage: issues sequential PC requests to instruction memory,
// buffers in-order responses in a small FIFO and redirects on jumps and taken branches.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        AnyStall,
    input  logic        Jump_IDM1,
    input  logic [25:0] JumpTgt_IDM1,
    input  logic        BrTaken_EX,
    input  logic [31:0] BrTgt_EX,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemGnt,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    output logic [31:0] FetchData_IF,
    output logic        FetchValid_IF,
    output logic [31:0] Pc_IF,
    output logic        FetchStall_IF
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      r_pc;
    logic [31:0]      r_instr [DEPTH];
    logic [31:0]      r_ipc   [DEPTH];
    logic [31:0]      r_qpc   [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_qrd;
    logic [PTR_W-1:0] r_qwr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_out_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_valid;
    logic             w_pop;
    logic             w_jredir;
    logic             w_bredir;
    logic             w_redirect;
    logic [SUM_W-1:0] w_inflight;
    logic             w_req;
    logic             w_accept;
    logic             w_rsp;
    logic             w_drop_now;
    logic             w_push;
    logic [3:0]       w_region;
    logic [31:0]      w_target;

    // Handshake, redirect and FIFO control; outputs are forced idle while reset is high.
    always_comb begin
        w_valid    = (r_count != '0) && !reset;
        w_pop      = w_valid && !AnyStall;
        w_jredir   = w_pop && Jump_IDM1;
        w_bredir   = BrTaken_EX && !reset;
        w_redirect = w_jredir || w_bredir;
        w_inflight = SUM_W'(r_count) + SUM_W'(r_out_cnt);
        w_req      = !reset && !w_redirect && (w_inflight < SUM_W'(DEPTH));
        w_accept   = w_req && ImemGnt;
        w_rsp      = ImemRspValid && (r_out_cnt != '0) && !reset;
        w_drop_now = w_rsp && (r_drop_cnt != '0);
        w_push     = w_rsp && !w_drop_now && !w_redirect;
        // Region of the sequential successor: carry out of bits [27:2] bumps [31:28].
        w_region   = Pc_IF[31:28] + {3'b000, &Pc_IF[27:2]};
        w_target   = w_bredir ? BrTgt_EX : {w_region, JumpTgt_IDM1, 2'b00};
    end

    assign ImemReq       = w_req;
    assign ImemAddr      = r_pc;
    assign FetchValid_IF = w_valid;
    assign FetchData_IF  = w_valid ? r_instr[r_rd] : 32'h0000_0000;
    assign Pc_IF         = w_valid ? r_ipc[r_rd] : RESET_PC;
    assign FetchStall_IF = !w_valid;

    // Payload storage: response FIFO and the PCs of requests still in flight.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr] <= ImemRspData;
            r_ipc[r_wr]   <= r_qpc[r_qrd];
        end
        if (w_accept) begin
            r_qpc[r_qwr] <= r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_rd       <= '0;
            r_wr       <= '0;
            r_qrd      <= '0;
            r_qwr      <= '0;
            r_count    <= '0;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_out_cnt <= r_out_cnt + CNT_W'(w_accept) - CNT_W'(w_rsp);
            if (w_accept) begin
                r_qwr <= r_qwr + PTR_W'(1);
            end
            if (w_rsp) begin
                r_qrd <= r_qrd + PTR_W'(1);
            end
            if (w_redirect) begin
                // Every request still outstanding belongs to the abandoned path.
                r_pc       <= w_target;
                r_rd       <= '0;
                r_wr       <= '0;
                r_count    <= '0;
                r_drop_cnt <= r_out_cnt - CNT_W'(w_rsp);
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr <= r_wr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd <= r_rd + PTR_W'(1);
                end
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
                if (w_drop_now) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: in-order memory model with random grant/latency and an
// architectural next-PC model that predicts every word decode should receive.
module tb_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned DEPTH    = 4;

    logic        clk;
    logic        reset;
    logic        AnyStall;
    logic        Jump_IDM1;
    logic [25:0] JumpTgt_IDM1;
    logic        BrTaken_EX;
    logic [31:0] BrTgt_EX;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRspValid;
    logic [31:0] ImemRspData;
    logic [31:0] FetchData_IF;
    logic        FetchValid_IF;
    logic [31:0] Pc_IF;
    logic        FetchStall_IF;

    fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .AnyStall(AnyStall), .Jump_IDM1(Jump_IDM1),
        .JumpTgt_IDM1(JumpTgt_IDM1), .BrTaken_EX(BrTaken_EX), .BrTgt_EX(BrTgt_EX),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemGnt(ImemGnt),
        .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
        .FetchData_IF(FetchData_IF), .FetchValid_IF(FetchValid_IF), .Pc_IF(Pc_IF),
        .FetchStall_IF(FetchStall_IF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decode's view of the head word: J (2) or JAL (3).
    assign Jump_IDM1    = (FetchData_IF[31:27] == 5'b00001);
    assign JumpTgt_IDM1 = FetchData_IF[25:0];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          g_identity = 1'b1;
    bit          g_patch = 1'b0;
    int          g_gnt_pct = 100;
    int          g_lat_min = 1;
    int          g_lat_max = 1;
    logic [31:0] m_exp_pc = RESET_PC;

    logic        s_req, s_acc, s_valid, s_pop, s_stall_o, s_stall_i, s_br;
    logic [31:0] s_addr, s_data, s_pc, s_exp_pc, s_exp_data;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (g_identity) begin
            if (g_patch && a == 32'h0000_0010) return 32'h0800_0040;
            return a;
        end
        h = a * 32'h9E37_79B1;
        if (h[31:29] == 3'd0) return {6'b000010, h[25:0]};
        return {6'b001000, h[27:2]};
    endfunction

    function automatic bit is_jump(input logic [31:0] w);
        return w[31:27] == 5'b00001;
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] w);
        logic [31:0] n;
        n = pc + 32'd4;
        return {n[31:28], w[25:0], 2'b00};
    endfunction

    // One clock: sample outputs, advance memory and PC models, drive next memory inputs.
    task automatic cycle();
        #2;
        s_req      = ImemReq;
        s_addr     = ImemAddr;
        s_acc      = ImemReq & ImemGnt;
        s_valid    = FetchValid_IF;
        s_data     = FetchData_IF;
        s_pc       = Pc_IF;
        s_stall_o  = FetchStall_IF;
        s_stall_i  = AnyStall;
        s_br       = BrTaken_EX & !reset;
        s_pop      = s_valid & !AnyStall & !reset;
        s_exp_pc   = m_exp_pc;
        s_exp_data = mem_word(m_exp_pc);
        if (reset) begin
            mq.delete();
            m_exp_pc = RESET_PC;
        end else begin
            if (ImemRspValid && mq.size() > 0) void'(mq.pop_front());
            if (s_acc) mq.push_back('{addr: s_addr, due: cyc + $urandom_range(g_lat_min, g_lat_max)});
            if (s_br) m_exp_pc = BrTgt_EX;
            else if (s_pop) m_exp_pc = is_jump(s_exp_data) ? jump_target(s_exp_pc, s_exp_data)
                                                            : s_exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        cyc++;
        ImemGnt = ($urandom_range(0, 99) < g_gnt_pct);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            ImemRspValid = 1'b1;
            ImemRspData  = mem_word(mq[0].addr);
        end else begin
            ImemRspValid = 1'b0;
            ImemRspData  = 32'h0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; AnyStall = 1'b0; BrTaken_EX = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        g_identity = 1'b1; g_patch = 1'b0; g_gnt_pct = 100; g_lat_min = 1; g_lat_max = 1;
        reset = 1'b1; AnyStall = 1'b0; BrTaken_EX = 1'b0;
        cycle();
        #2;
        n_vec++; if (FetchValid_IF !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", FetchValid_IF); end
        n_vec++; if (FetchData_IF !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h expected 0", FetchData_IF); end
        n_vec++; if (Pc_IF !== RESET_PC) begin n_err++; $display("FAIL rst_pc: got %h expected %h", Pc_IF, RESET_PC); end
        n_vec++; if (ImemReq !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b expected 0", ImemReq); end
        n_vec++; if (FetchStall_IF !== 1'b1) begin n_err++; $display("FAIL rst_stall: got %b expected 1", FetchStall_IF); end
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_sequence();
        logic [31:0] exp_addr;
        exp_addr = RESET_PC;
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            AnyStall = 1'b0;
            cycle();
            n_vec++;
            if (s_valid !== (k >= 3)) begin n_err++; $display("FAIL seq_valid k=%0d: got %b expected %b", k, s_valid, k >= 3); end
            if (s_acc) begin
                n_vec++;
                if (s_addr !== exp_addr) begin n_err++; $display("FAIL seq_addr: got %h expected %h", s_addr, exp_addr); end
                exp_addr = exp_addr + 32'd4;
            end
            if (s_pop) begin
                n_vec++; if (s_pc !== s_exp_pc) begin n_err++; $display("FAIL seq_pc: got %h expected %h", s_pc, s_exp_pc); end
                n_vec++; if (s_data !== s_exp_data) begin n_err++; $display("FAIL seq_data: got %h expected %h", s_data, s_exp_data); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            AnyStall = (k >= 5 && k <= 8);
            cycle();
            if (k >= 5 && k <= 8) begin
                n_vec++; if (s_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid k=%0d: got %b expected 1", k, s_valid); end
                n_vec++; if (s_data !== 32'h8) begin n_err++; $display("FAIL stall_data k=%0d: got %h expected 00000008", k, s_data); end
                n_vec++; if (s_pc !== 32'h8) begin n_err++; $display("FAIL stall_pc k=%0d: got %h expected 00000008", k, s_pc); end
            end
            if (k == 8) begin
                n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL stall_req_full: got %b expected 0", s_req); end
            end
            if (k >= 9 && k <= 12) begin
                n_vec++; if (s_valid !== 1'b1) begin n_err++; $display("FAIL stall_resume k=%0d: got %b expected 1", k, s_valid); end
            end
            if (s_pop) begin
                n_vec++; if (s_pc !== s_exp_pc) begin n_err++; $display("FAIL stall_pc_stream: got %h expected %h", s_pc, s_exp_pc); end
                n_vec++; if (s_data !== s_exp_data) begin n_err++; $display("FAIL stall_data_stream: got %h expected %h", s_data, s_exp_data); end
            end
        end
    endtask

    task automatic test_jump();
        bit jumped, addr_done, pop_done;
        jumped = 1'b0; addr_done = 1'b0; pop_done = 1'b0;
        g_patch = 1'b1; g_lat_min = 3; g_lat_max = 3;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            AnyStall = 1'b0;
            cycle();
            if (jumped && s_acc && !addr_done) begin
                addr_done = 1'b1;
                n_vec++; if (s_addr !== 32'h100) begin n_err++; $display("FAIL jump_addr: got %h expected 00000100", s_addr); end
            end
            if (s_pop) begin
                if (jumped && !pop_done) begin
                    pop_done = 1'b1;
                    n_vec++; if (s_pc !== 32'h100) begin n_err++; $display("FAIL jump_first_pc: got %h expected 00000100", s_pc); end
                end
                n_vec++; if (s_pc !== s_exp_pc) begin n_err++; $display("FAIL jump_pc_stream: got %h expected %h", s_pc, s_exp_pc); end
                n_vec++; if (s_data !== s_exp_data) begin n_err++; $display("FAIL jump_data_stream: got %h expected %h", s_data, s_exp_data); end
                if (s_pc == 32'h10) jumped = 1'b1;
            end
        end
        n_vec++; if (pop_done !== 1'b1) begin n_err++; $display("FAIL jump_seen: got %b expected 1", pop_done); end
    endtask

    task automatic test_jump_branch();
        bit fired, addr_done;
        fired = 1'b0; addr_done = 1'b0;
        g_patch = 1'b1; g_lat_min = 3; g_lat_max = 3;
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            AnyStall   = 1'b0;
            BrTaken_EX = !fired && FetchValid_IF && (Pc_IF == 32'h10);
            BrTgt_EX   = 32'h200;
            cycle();
            if (s_acc && fired) begin
                n_vec++; if (s_addr === 32'h100) begin n_err++; $display("FAIL jb_no_jump_tgt: got %h expected not 00000100", s_addr); end
                if (!addr_done) begin
                    addr_done = 1'b1;
                    n_vec++; if (s_addr !== 32'h200) begin n_err++; $display("FAIL jb_addr: got %h expected 00000200", s_addr); end
                end
            end
            if (s_pop) begin
                n_vec++; if (s_pc !== s_exp_pc) begin n_err++; $display("FAIL jb_pc_stream: got %h expected %h", s_pc, s_exp_pc); end
                n_vec++; if (s_data !== s_exp_data) begin n_err++; $display("FAIL jb_data_stream: got %h expected %h", s_data, s_exp_data); end
            end
            if (s_br) fired = 1'b1;
        end
        BrTaken_EX = 1'b0;
        n_vec++; if (addr_done !== 1'b1) begin n_err++; $display("FAIL jb_redirect_seen: got %b expected 1", addr_done); end
    endtask

    task automatic test_reset_mid();
        g_patch = 1'b0; g_lat_min = 2; g_lat_max = 2;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            AnyStall = 1'b1;
            cycle();
        end
        reset = 1'b1;
        cycle();
        n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b expected 0", s_valid); end
        n_vec++; if (s_req !== 1'b0) begin n_err++; $display("FAIL rmid_req: got %b expected 0", s_req); end
        n_vec++; if (s_stall_o !== 1'b1) begin n_err++; $display("FAIL rmid_stall: got %b expected 1", s_stall_o); end
        reset = 1'b0; AnyStall = 1'b0;
        cycle();
        n_vec++; if (s_req !== 1'b1) begin n_err++; $display("FAIL rmid_req_after: got %b expected 1", s_req); end
        n_vec++; if (s_addr !== RESET_PC) begin n_err++; $display("FAIL rmid_addr_after: got %h expected %h", s_addr, RESET_PC); end
        n_vec++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid_after: got %b expected 0", s_valid); end
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (s_pop) begin
                n_vec++; if (s_pc !== s_exp_pc) begin n_err++; $display("FAIL rmid_pc_stream: got %h expected %h", s_pc, s_exp_pc); end
                n_vec++; if (s_data !== s_exp_data) begin n_err++; $display("FAIL rmid_data_stream: got %h expected %h", s_data, s_exp_data); end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] r, prev_data;
        bit          prev_hold;
        int          idle, pops;
        idle = 0; pops = 0; prev_hold = 1'b0; prev_data = 32'h0;
        g_identity = 1'b0; g_gnt_pct = 50; g_lat_min = 1; g_lat_max = 4;
        do_reset();
        for (int k = 0; k < 2000; k++) begin
            r          = $urandom();
            AnyStall   = ($urandom_range(0, 99) < 30);
            BrTaken_EX = ($urandom_range(0, 99) < 3);
            BrTgt_EX   = {r[31:2], 2'b00};
            cycle();
            n_vec++;
            if (s_stall_o !== !s_valid) begin n_err++; $display("FAIL rnd_stall_out: got %b expected %b", s_stall_o, !s_valid); end
            if (s_acc) begin
                n_vec++; if (s_addr[1:0] !== 2'b00) begin n_err++; $display("FAIL rnd_addr_align: got %h expected low bits 00", s_addr); end
            end
            if (prev_hold) begin
                n_vec++; if (s_valid !== 1'b1 || s_data !== prev_data) begin
                    n_err++; $display("FAIL rnd_hold: got %b/%h expected 1/%h", s_valid, s_data, prev_data);
                end
            end
            prev_hold = s_valid && s_stall_i && !s_br;
            prev_data = s_data;
            if (s_pop) begin
                pops++; idle = 0;
                n_vec++; if (s_pc !== s_exp_pc) begin n_err++; $display("FAIL rnd_pc: got %h expected %h", s_pc, s_exp_pc); end
                n_vec++; if (s_data !== s_exp_data) begin n_err++; $display("FAIL rnd_data: got %h expected %h", s_data, s_exp_data); end
            end else begin
                idle++;
                if (idle == 64) begin
                    n_vec++; n_err++; $display("FAIL rnd_progress: got no pop for 64 cycles expected progress");
                    idle = 0;
                end
            end
        end
        BrTaken_EX = 1'b0; AnyStall = 1'b0;
        n_vec++; if (pops < 200) begin n_err++; $display("FAIL rnd_pop_count: got %0d expected at least 200", pops); end
    endtask

    initial begin
        reset = 1'b1; AnyStall = 1'b0; BrTaken_EX = 1'b0; BrTgt_EX = 32'h0;
        ImemGnt = 1'b0; ImemRspValid = 1'b0; ImemRspData = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequence();
        test_stall();
        test_jump();
        test_jump_branch();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
